idct_transpose_buf: RTL

- Double-buffered 8x8 transpose store between the row IDCT and column IDCT peripherals in the JPEG decode path.
- Accepts one row-IDCT output row of 8 signed coefficients per handshake and emits columns for the column IDCT.
- Lets the row pass of block N+1 overlap the column pass of block N, with no CPU read-back and re-write through MMIO.

---
 rtl/idct_transpose_buf.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/idct_transpose_buf.sv
`default_nettype none
// ============================================================================
//  Module      : idct_transpose_buf
//  Description : Double-buffered NxN transpose store that sits between the
//                row IDCT and the column IDCT. Rows are written into one
//                bank while columns of the previously completed block are
//                read out of the other bank.
//  Revision    : 1.0  initial release
// ============================================================================
module idct_transpose_buf #(
    parameter int DATA_W = 32,
    parameter int N      = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    // row side (producer: row IDCT)
    input  logic                  row_valid,
    output logic                  row_ready,
    input  logic [N*DATA_W-1:0]   row_data,
    // column side (consumer: column IDCT)
    output logic                  col_valid,
    input  logic                  col_ready,
    output logic [N*DATA_W-1:0]   col_data,
    output logic [2:0]            col_idx,
    output logic                  blk_done,
    // status
    output logic [1:0]            bank_full
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               IDX_W    = 3;
    localparam int               ROW_W    = N * DATA_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // ------------------------------------------------------------------------
    // Bank storage: two banks, each N rows of N packed coefficients.
    // Contents are never reset; the full flags decide what is meaningful.
    // ------------------------------------------------------------------------
    logic [ROW_W-1:0] bank_q [2][N];

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    logic             wr_bank_q, wr_bank_d;
    logic [IDX_W-1:0] wr_row_q,  wr_row_d;
    logic             rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] rd_col_q,  rd_col_d;
    logic [1:0]       full_q,    full_d;
    logic             blk_done_q, blk_done_d;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic             row_accept;
    logic             col_accept;
    logic             row_last;
    logic             col_last;
    logic             clear;

    // Ready/valid come straight from the full flags, so ready never depends
    // on the opposite side's handshake in the same cycle.
    assign row_ready  = !full_q[wr_bank_q];
    assign col_valid  = full_q[rd_bank_q];

    assign row_accept = row_valid && row_ready;
    assign col_accept = col_valid && col_ready;
    assign row_last   = row_accept && (wr_row_q == LAST_IDX);
    assign col_last   = col_accept && (rd_col_q == LAST_IDX);
    assign clear      = !resetn || flush;

    assign col_idx    = rd_col_q;
    assign blk_done   = blk_done_q;
    assign bank_full  = full_q;

    // ------------------------------------------------------------------------
    // Row write enables, one per (bank, row) slot
    // ------------------------------------------------------------------------
    logic [N-1:0] row_we [2];

    // Decode the current write pointer into a one-hot enable per slot.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            row_we[b] = '0;
            for (int r = 0; r < N; r++) begin
                if (row_accept && (wr_bank_q == 1'(b)) && (wr_row_q == IDX_W'(r))) begin
                    row_we[b][r] = 1'b1;
                end
            end
        end
    end

    // Store an accepted row into its slot; a row accepted alongside a flush
    // lands in storage but is orphaned because the pointers are cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < N; r++) begin
                if (row_we[b][r]) begin
                    bank_q[b][r] <= row_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Column read mux
    // ------------------------------------------------------------------------
    logic [ROW_W-1:0] rd_rows [N];

    // Pick the rows of the bank being read.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            rd_rows[r] = bank_q[rd_bank_q][r];
        end
    end

    // Gather element rd_col of every row into one column word (row r -> lane r).
    always_comb begin
        col_data = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (rd_col_q == IDX_W'(c)) begin
                    col_data[r*DATA_W +: DATA_W] = rd_rows[r][c*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------

    // Advance write/read pointers and update the full flags; fill and free
    // always target different banks, so both updates can apply together.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_row_d   = wr_row_q;
        rd_bank_d  = rd_bank_q;
        rd_col_d   = rd_col_q;
        full_d     = full_q;
        blk_done_d = 1'b0;

        if (row_accept) begin
            if (row_last) begin
                wr_row_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_row_d = wr_row_q + 1'b1;
            end
        end

        if (col_accept) begin
            if (col_last) begin
                rd_col_d          = '0;
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
                blk_done_d        = 1'b1;
            end else begin
                rd_col_d = rd_col_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------

    // Control state; reset and flush both discard every in-flight block.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_bank_q  <= 1'b0;
            wr_row_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_col_q   <= '0;
            full_q     <= 2'b00;
            blk_done_q <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_row_q   <= wr_row_d;
            rd_bank_q  <= rd_bank_d;
            rd_col_q   <= rd_col_d;
            full_q     <= full_d;
            blk_done_q <= blk_done_d;
        end
    end

endmodule
`default_nettype wire
